// File: rtl/intr_ctrl.sv
// ---------------------------------------------------------------------------
// intr_ctrl
//
// Interrupt controller for a small core with two interrupt sources: a UART
// receiver and a periodic timer. Events are collected in a pending register.
// An interrupt request is raised towards the core when interrupts are
// enabled. When the core takes the icall, every pending source is snapshotted
// into irq_cause in one go. The core then writes ack to end the service.
//
// Ports
//   clk           in   single clock, all state updates on its rising edge
//   rst           in   synchronous, active-high reset
//   rx_valid      in   one-cycle strobe: UART byte received
//   rx_data       in   [7:0] received byte, valid with rx_valid
//   timer_period  in   [TIMER_W-1:0] timer tick period in cycles, 0 = off
//   intr_en       in   core status-register interrupt enable
//   icall_taken   in   one-cycle strobe: core executed the injected icall
//   ack           in   one-cycle strobe: core acknowledged the interrupt
//   ovr_clr       in   one-cycle strobe: clear sticky error flags
//   irq           out  ask the core to inject icall at the next boundary
//   irq_cause     out  [1:0] serviced sources, bit0 rx, bit1 timer
//   rx_byte       out  [7:0] most recently received byte
//   rx_overrun    out  sticky: an rx event was lost
//   timer_miss    out  sticky: a timer tick was lost
//   dbg_state     out  [1:0] FSM state (0 IDLE, 1 REQ, 2 SERVE)
//
// Handshake: irq is a level request. It stays high in REQ until the core
// answers with icall_taken. The core may also withdraw the request by
// dropping intr_en. Each of icall_taken and ack is honoured only in the
// state that expects it; in any other state it is ignored.
// ---------------------------------------------------------------------------
module intr_ctrl #(
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    input  logic [TIMER_W-1:0] timer_period,
    input  logic               intr_en,
    input  logic               icall_taken,
    input  logic               ack,
    input  logic               ovr_clr,
    output logic               irq,
    output logic [1:0]         irq_cause,
    output logic [7:0]         rx_byte,
    output logic               rx_overrun,
    output logic               timer_miss,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        SERVE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] count_q, count_d;
    logic [1:0]         pend_q, pend_d;
    logic [1:0]         cause_q, cause_d;
    logic [7:0]         rx_byte_q, rx_byte_d;
    logic               overrun_q, overrun_d;
    logic               miss_q, miss_d;

    logic               tick;
    logic [1:0]         events;
    logic               overrun_set;
    logic               miss_set;

    // The tick uses >= rather than == so that shrinking timer_period below
    // the current count ticks and wraps at once, instead of running the
    // counter all the way round the TIMER_W range.
    assign tick = (timer_period != '0) &&
                  (count_q >= (timer_period - TIMER_W'(1)));

    always_comb begin
        count_d = count_q;
        if (timer_period == '0) begin
            count_d = '0;
        end else if (tick) begin
            count_d = '0;
        end else begin
            count_d = count_q + TIMER_W'(1);
        end
    end

    assign events = {tick, rx_valid};

    // A source counts as still outstanding while its pend bit is set. It
    // also counts while its cause bit is being serviced and ack has not
    // arrived yet.
    assign overrun_set = rx_valid &&
                         (pend_q[0] || ((state_q == SERVE) && cause_q[0]));
    assign miss_set    = tick &&
                         (pend_q[1] || ((state_q == SERVE) && cause_q[1]));

    always_comb begin
        rx_byte_d = rx_valid ? rx_data : rx_byte_q;
        // A setting event in the same cycle beats ovr_clr.
        overrun_d = (overrun_q & ~ovr_clr) | overrun_set;
        miss_d    = (miss_q & ~ovr_clr) | miss_set;
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q | events;
        cause_d = cause_q;
        case (state_q)
            IDLE: begin
                if ((pend_q != 2'b00) && intr_en) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (icall_taken) begin
                    // Events arriving in the icall cycle are serviced by
                    // this icall too, so the whole pend register empties.
                    state_d = SERVE;
                    cause_d = pend_q | events;
                    pend_d  = 2'b00;
                end else if (!intr_en) begin
                    state_d = IDLE;
                end
            end
            SERVE: begin
                if (ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            pend_q    <= 2'b00;
            cause_q   <= 2'b00;
            rx_byte_q <= 8'h00;
            overrun_q <= 1'b0;
            miss_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pend_q    <= pend_d;
            cause_q   <= cause_d;
            rx_byte_q <= rx_byte_d;
            overrun_q <= overrun_d;
            miss_q    <= miss_d;
        end
    end

    assign irq        = (state_q == REQ);
    assign irq_cause  = cause_q;
    assign rx_byte    = rx_byte_q;
    assign rx_overrun = overrun_q;
    assign timer_miss = miss_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;

    logic        clk;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [31:0] timer_period;
    logic        intr_en;
    logic        icall_taken;
    logic        ack;
    logic        ovr_clr;
    logic        irq;
    logic [1:0]  irq_cause;
    logic [7:0]  rx_byte;
    logic        rx_overrun;
    logic        timer_miss;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected rx bytes and irq causes, pushed when stimulus is driven.
    logic [7:0] exp_q[$];
    logic [7:0] exp;

    intr_ctrl #(.TIMER_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .timer_period (timer_period),
        .intr_en      (intr_en),
        .icall_taken  (icall_taken),
        .ack          (ack),
        .ovr_clr      (ovr_clr),
        .irq          (irq),
        .irq_cause    (irq_cause),
        .rx_byte      (rx_byte),
        .rx_overrun   (rx_overrun),
        .timer_miss   (timer_miss),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are read 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst          = 1'b1;
        rx_valid     = 1'b0;
        rx_data      = 8'h00;
        timer_period = 32'd0;
        intr_en      = 1'b0;
        icall_taken  = 1'b0;
        ack          = 1'b0;
        ovr_clr      = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // ---------------- drivers ----------------
    task automatic drive_rx(input logic [7:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        exp_q.push_back(d);
    endtask

    task automatic drive_icall(input logic [1:0] cause);
        icall_taken = 1'b1;
        exp_q.push_back({6'b0, cause});
    endtask

    task automatic release_strobes();
        rx_valid    = 1'b0;
        icall_taken = 1'b0;
        ack         = 1'b0;
        ovr_clr     = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %0b want 0", irq); end
        n_checks++; if (irq_cause !== 2'b00) begin n_fail++; $display("FAIL reset_cause: got %b want 00", irq_cause); end
        n_checks++; if (rx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_rx_byte: got %h want 00", rx_byte); end
        n_checks++; if (rx_overrun !== 1'b0 || timer_miss !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got ovr=%0b miss=%0b want 0 0", rx_overrun, timer_miss); end
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    endtask

    task automatic test_rx_basic();
        apply_reset();
        intr_en = 1'b1;
        drive_rx(8'h41);
        step();
        release_strobes();
        exp = exp_q.pop_front();
        n_checks++; if (rx_byte !== exp) begin n_fail++; $display("FAIL rx_byte_t1: got %h want %h", rx_byte, exp); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rx_irq_t1: got %0b want 0", irq); end
        step();
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL rx_irq_t2: got %0b want 1", irq); end
        drive_icall(2'b01);
        step();
        release_strobes();
        exp = exp_q.pop_front();
        n_checks++; if (irq_cause !== exp[1:0]) begin n_fail++; $display("FAIL rx_cause: got %b want %b", irq_cause, exp[1:0]); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rx_irq_serve: got %0b want 0", irq); end
        ack = 1'b1;
        step();
        release_strobes();
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rx_ack_idle: got %0d want 0", dbg_state); end
        step();
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rx_no_reirq: got %0b want 0", irq); end
    endtask

    task automatic test_timer();
        apply_reset();
        intr_en      = 1'b1;
        timer_period = 32'd4;
        for (int i = 1; i <= 4; i++) begin
            step();
            n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL tmr_pre_irq step %0d: got %0b want 0", i, irq); end
        end
        step();
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL tmr_irq: got %0b want 1", irq); end
        step();
        step();
        n_checks++; if (timer_miss !== 1'b0) begin n_fail++; $display("FAIL tmr_miss_early: got %0b want 0", timer_miss); end
        step();
        n_checks++; if (timer_miss !== 1'b1) begin n_fail++; $display("FAIL tmr_miss_set: got %0b want 1", timer_miss); end
        ovr_clr = 1'b1;
        step();
        release_strobes();
        n_checks++; if (timer_miss !== 1'b0) begin n_fail++; $display("FAIL tmr_miss_clr: got %0b want 0", timer_miss); end
        timer_period = 32'd0;
        drive_icall(2'b10);
        step();
        release_strobes();
        exp = exp_q.pop_front();
        n_checks++; if (irq_cause !== exp[1:0]) begin n_fail++; $display("FAIL tmr_cause: got %b want %b", irq_cause, exp[1:0]); end

        // Shrinking the period below the running count ticks immediately.
        apply_reset();
        timer_period = 32'd8;
        for (int i = 0; i < 5; i++) step();
        timer_period = 32'd3;
        step();
        timer_period = 32'd0;
        intr_en = 1'b1;
        step();
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL tmr_shrink_irq: got %0b want 1", irq); end
        drive_icall(2'b10);
        step();
        release_strobes();
        exp = exp_q.pop_front();
        n_checks++; if (irq_cause !== exp[1:0]) begin n_fail++; $display("FAIL tmr_shrink_cause: got %b want %b", irq_cause, exp[1:0]); end
    endtask

    task automatic test_intr_en();
        int bad;
        apply_reset();
        timer_period = 32'd4;
        for (int i = 0; i < 4; i++) step();
        timer_period = 32'd0;
        drive_rx(8'h3c);
        step();
        release_strobes();
        exp = exp_q.pop_front();
        n_checks++; if (rx_byte !== exp) begin n_fail++; $display("FAIL en_rx_byte: got %h want %h", rx_byte, exp); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (irq !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL en_masked: got %0d irq cycles want 0", bad); end
        intr_en = 1'b1;
        step();
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL en_irq: got %0b want 1", irq); end
        intr_en = 1'b0;
        step();
        n_checks++; if (irq !== 1'b0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL en_withdraw: got irq=%0b st=%0d want 0 0", irq, dbg_state); end
        intr_en = 1'b1;
        step();
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL en_reassert: got %0b want 1", irq); end
        drive_icall(2'b11);
        step();
        release_strobes();
        exp = exp_q.pop_front();
        n_checks++; if (irq_cause !== exp[1:0]) begin n_fail++; $display("FAIL en_cause: got %b want %b", irq_cause, exp[1:0]); end
    endtask

    task automatic test_overrun();
        apply_reset();
        intr_en = 1'b1;
        drive_rx(8'h10);
        step();
        release_strobes();
        exp = exp_q.pop_front();
        n_checks++; if (rx_byte !== exp) begin n_fail++; $display("FAIL ovr_rx1: got %h want %h", rx_byte, exp); end
        step();
        ack = 1'b1;
        step();
        release_strobes();
        n_checks++; if (irq !== 1'b1 || dbg_state !== 2'd1) begin n_fail++; $display("FAIL ovr_ack_ignored: got irq=%0b st=%0d want 1 1", irq, dbg_state); end
        drive_icall(2'b01);
        step();
        release_strobes();
        exp = exp_q.pop_front();
        n_checks++; if (irq_cause !== exp[1:0]) begin n_fail++; $display("FAIL ovr_cause: got %b want %b", irq_cause, exp[1:0]); end
        drive_rx(8'h55);
        step();
        release_strobes();
        exp = exp_q.pop_front();
        n_checks++; if (rx_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %0b want 1", rx_overrun); end
        n_checks++; if (rx_byte !== exp) begin n_fail++; $display("FAIL ovr_rx2: got %h want %h", rx_byte, exp); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL ovr_serve_irq: got %0b want 0", irq); end
        ack = 1'b1;
        step();
        release_strobes();
        n_checks++; if (irq !== 1'b0 || irq_cause !== 2'b01) begin n_fail++; $display("FAIL ovr_after_ack: got irq=%0b cause=%b want 0 01", irq, irq_cause); end
        step();
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL ovr_reirq: got %0b want 1", irq); end
        ovr_clr = 1'b1;
        drive_rx(8'h66);
        step();
        release_strobes();
        exp = exp_q.pop_front();
        n_checks++; if (rx_overrun !== 1'b1 || rx_byte !== exp) begin n_fail++; $display("FAIL ovr_set_wins: got ovr=%0b byte=%h want 1 %h", rx_overrun, rx_byte, exp); end
        ovr_clr = 1'b1;
        step();
        release_strobes();
        n_checks++; if (rx_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clr: got %0b want 0", rx_overrun); end
        drive_icall(2'b01);
        step();
        release_strobes();
        exp = exp_q.pop_front();
        n_checks++; if (irq_cause !== exp[1:0]) begin n_fail++; $display("FAIL ovr_cause2: got %b want %b", irq_cause, exp[1:0]); end
        ack = 1'b1;
        step();
        release_strobes();
        icall_taken = 1'b1;
        step();
        release_strobes();
        n_checks++; if (dbg_state !== 2'd0 || irq_cause !== 2'b01) begin n_fail++; $display("FAIL ovr_icall_ignored: got st=%0d cause=%b want 0 01", dbg_state, irq_cause); end
    endtask

    task automatic test_reset_mid();
        int bad;
        apply_reset();
        intr_en = 1'b1;
        drive_rx(8'h21);
        step();
        release_strobes();
        exp = exp_q.pop_front();
        n_checks++; if (rx_byte !== exp) begin n_fail++; $display("FAIL rstm_rx: got %h want %h", rx_byte, exp); end
        step();
        drive_icall(2'b01);
        step();
        release_strobes();
        exp = exp_q.pop_front();
        n_checks++; if (irq_cause !== exp[1:0] || dbg_state !== 2'd2) begin n_fail++; $display("FAIL rstm_serve: got cause=%b st=%0d want %b 2", irq_cause, dbg_state, exp[1:0]); end
        timer_period = 32'd1;
        step();
        timer_period = 32'd0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if ({irq, irq_cause, rx_byte, rx_overrun, timer_miss, dbg_state} !== 15'd0) begin n_fail++; $display("FAIL rstm_outputs: got irq=%0b cause=%b byte=%h ovr=%0b miss=%0b st=%0d want all 0", irq, irq_cause, rx_byte, rx_overrun, timer_miss, dbg_state); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (irq !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rstm_no_irq: got %0d irq cycles want 0", bad); end
    endtask

    task automatic test_back_to_back();
        int bad;
        apply_reset();
        intr_en      = 1'b1;
        timer_period = 32'd1;
        step();
        timer_period = 32'd0;
        step();
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL b2b_irq: got %0b want 1", irq); end
        drive_rx(8'h77);
        drive_icall(2'b11);
        step();
        release_strobes();
        exp = exp_q.pop_front();
        n_checks++; if (rx_byte !== exp) begin n_fail++; $display("FAIL b2b_rx: got %h want %h", rx_byte, exp); end
        exp = exp_q.pop_front();
        n_checks++; if (irq_cause !== exp[1:0]) begin n_fail++; $display("FAIL b2b_cause: got %b want %b", irq_cause, exp[1:0]); end
        n_checks++; if (rx_overrun !== 1'b0 || irq !== 1'b0) begin n_fail++; $display("FAIL b2b_flags: got ovr=%0b irq=%0b want 0 0", rx_overrun, irq); end
        ack = 1'b1;
        step();
        release_strobes();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (irq !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_pend_empty: got %0d irq cycles want 0", bad); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        apply_reset();
        test_reset();
        test_rx_basic();
        test_timer();
        test_intr_en();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
